muldiv_seq: RTL and testbench

- Multi-cycle sequencer for RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. It sits beside the single-cycle ALU in EX.
- Accepts one operation via valid/ready, iterates a shift-add multiplier or restoring divider for XLEN cycles, applies sign fix-up, and holds the result until the consumer takes it.
- EX stalls on busy. A pipeline flush aborts any operation in progress.

---
 rtl/muldiv_seq_pkg.sv | 45 ++++
 rtl/muldiv_seq_if.sv | 34 +++
 rtl/muldiv_sign_fix.sv | 43 ++++
 rtl/muldiv_seq.sv | 177 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_seq_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_seq_pkg
//   Shared definitions for the RV32M multiply/divide sequencer:
//   - md_op_e    : funct3 encodings of MUL..REMU
//   - md_state_e : sequencer state encodings
//   - default widths (data width, iteration counter width, iteration count)
//   - decode helpers for operation class and operand signedness
// -----------------------------------------------------------------------------
package muldiv_seq_pkg;

  localparam int MD_XLEN     = 32;
  localparam int MD_CNT_W    = 6;        // 2**MD_CNT_W must exceed MD_XLEN
  localparam int MD_ITER_CNT = MD_XLEN;  // iterations of a full-length operation

  typedef enum logic [2:0] {
    MD_OP_MUL    = 3'd0,
    MD_OP_MULH   = 3'd1,
    MD_OP_MULHSU = 3'd2,
    MD_OP_MULHU  = 3'd3,
    MD_OP_DIV    = 3'd4,
    MD_OP_DIVU   = 3'd5,
    MD_OP_REM    = 3'd6,
    MD_OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_STATE_IDLE = 2'd0,
    MD_STATE_CALC = 2'd1,
    MD_STATE_DONE = 2'd2
  } md_state_e;

  // funct3[2] separates the multiply group from the divide group.
  function automatic logic md_is_mul(md_op_e op);
    return !op[2];
  endfunction

  function automatic logic md_rs1_signed(md_op_e op);
    return op inside {MD_OP_MULH, MD_OP_MULHSU, MD_OP_DIV, MD_OP_REM};
  endfunction

  function automatic logic md_rs2_signed(md_op_e op);
    return op inside {MD_OP_MULH, MD_OP_DIV, MD_OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// -----------------------------------------------------------------------------
// muldiv_seq_if
//   Request/response bundle between EX and the multiply/divide sequencer.
//   req_valid/req_ready/req_op/req_rs1/req_rs2 : operation request
//   flush                                       : synchronous abort
//   resp_valid/resp_ready/resp_data             : result handshake
//   busy                                        : EX stall indication
//   modport master : the EX stage (requester / consumer)
//   modport slave  : the sequencer
// -----------------------------------------------------------------------------
interface muldiv_seq_if #(
  parameter int XLEN = muldiv_seq_pkg::MD_XLEN
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic            flush;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic            busy;

  modport master (
    output req_valid, req_op, req_rs1, req_rs2, flush, resp_ready,
    input  req_ready, resp_valid, resp_data, busy
  );

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, flush, resp_ready,
    output req_ready, resp_valid, resp_data, busy
  );
endinterface

// File: rtl/muldiv_sign_fix.sv
// -----------------------------------------------------------------------------
// muldiv_sign_fix (combinational)
//   Turns the unsigned magnitude result held in the accumulator into the
//   architectural result of the latched operation.
//   op     : latched funct3 operation
//   a_neg  : operand A (rs1) was negative and treated as signed
//   b_neg  : operand B (rs2) was negative and treated as signed
//   acc    : multiply -> 2*XLEN product magnitude
//            divide   -> {remainder, quotient} magnitudes
//   result : resp_data candidate
// -----------------------------------------------------------------------------
module muldiv_sign_fix
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  md_op_e            op,
  input  logic              a_neg,
  input  logic              b_neg,
  input  logic [2*XLEN-1:0] acc,
  output logic [XLEN-1:0]   result
);

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  // Product and quotient are negative when exactly one operand was; the
  // remainder always follows the dividend.
  assign prod = (a_neg ^ b_neg) ? -acc : acc;
  assign quo  = (a_neg ^ b_neg) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem  = a_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    case (op)
      MD_OP_MUL:                           result = prod[XLEN-1:0];
      MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU: result = prod[2*XLEN-1:XLEN];
      MD_OP_DIV, MD_OP_DIVU:               result = quo;
      default:                             result = rem;
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
//   Multi-cycle RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU sequencer that
//   sits beside the single-cycle ALU in EX. One operation is accepted through
//   valid/ready, iterated with a shift-add multiplier or restoring divider for
//   XLEN cycles, sign-corrected, and held until the consumer takes it.
//   Divide-by-zero and signed overflow are resolved at accept and complete in
//   one cycle. flush aborts everything and has priority over accept/handshake.
//
//   Ports: clk, rst_n (async active-low), bus (muldiv_seq_if.slave).
//
//   Build option: define MULDIV_EARLY_OUT_EN to let multiplies leave CALC as
//   soon as the remaining multiplier bits are zero (results unchanged).
// -----------------------------------------------------------------------------
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN  = MD_ITER_CNT,
  parameter int CNT_W = MD_CNT_W    // 2**CNT_W must exceed XLEN
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_seq_if.slave  bus
);

  localparam logic [XLEN-1:0]  OVF_DIVIDEND = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONES     = '1;
  localparam logic [CNT_W-1:0] ITER_LAST    = CNT_W'(XLEN);

  md_state_e         state_q, state_d;
  md_op_e            op_q;
  logic              a_neg_q, b_neg_q;
  logic [XLEN-1:0]   a_q;     // multiplicand, or dividend shifted out MSB-first
  logic [XLEN-1:0]   b_q;     // multiplier shifted out LSB-first, or divisor
  logic [2*XLEN-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   resp_data_q;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  md_op_e          req_op;
  logic            accept;
  logic            req_a_neg, req_b_neg;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_data;

  assign req_op    = md_op_e'(bus.req_op);
  assign accept    = bus.req_valid && (state_q == MD_STATE_IDLE) && !bus.flush;
  assign req_a_neg = md_rs1_signed(req_op) && bus.req_rs1[XLEN-1];
  assign req_b_neg = md_rs2_signed(req_op) && bus.req_rs2[XLEN-1];
  assign div_zero  = !md_is_mul(req_op) && (bus.req_rs2 == '0);
  assign div_ovf   = (req_op inside {MD_OP_DIV, MD_OP_REM})
                  && (bus.req_rs1 == OVF_DIVIDEND) && (bus.req_rs2 == ALL_ONES);
  assign special   = div_zero || div_ovf;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    special_data = '0;
    if (div_zero)
      special_data = (req_op inside {MD_OP_DIV, MD_OP_DIVU}) ? ALL_ONES : bus.req_rs1;
    else if (div_ovf)
      special_data = (req_op == MD_OP_DIV) ? OVF_DIVIDEND : '0;
  end

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  logic              iter_done;
  logic              early_out;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   fix_result;

  assign iter_done = (cnt_q == ITER_LAST);

`ifdef MULDIV_EARLY_OUT_EN
  // Once the multiplier is exhausted the remaining iterations are pure shifts.
  assign early_out = md_is_mul(op_q) && (b_q == '0) && !iter_done;
`else
  assign early_out = 1'b0;
`endif

  // Shift-add: the carry out of the upper-half add becomes the new MSB.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (b_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide on {remainder, quotient}. The shifted remainder needs
  // XLEN+1 bits; when its top bit is set it already exceeds the divisor.
  assign rem_sh   = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]};
  assign div_diff = rem_sh - {1'b0, b_q};
  assign div_ge   = rem_sh[XLEN] || !div_diff[XLEN];
  assign div_next = {(div_ge ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0]),
                     acc_q[XLEN-2:0], div_ge};

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .op     (op_q),
    .a_neg  (a_neg_q),
    .b_neg  (b_neg_q),
    .acc    (acc_q),
    .result (fix_result)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) state_q <= MD_STATE_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_STATE_IDLE: if (accept)    state_d = special ? MD_STATE_DONE : MD_STATE_CALC;
      MD_STATE_CALC: if (iter_done) state_d = MD_STATE_DONE;
      MD_STATE_DONE: if (bus.resp_ready) state_d = MD_STATE_IDLE;
      default:                      state_d = MD_STATE_IDLE;
    endcase
    if (bus.flush) state_d = MD_STATE_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath registers are reset too, so a reset mid-operation
    // leaves no stale partial result visible.
    if (!rst_n) begin
      op_q        <= MD_OP_MUL;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      resp_data_q <= '0;
    end else if (!bus.flush) begin
      if (accept) begin
        op_q    <= req_op;
        a_neg_q <= req_a_neg;
        b_neg_q <= req_b_neg;
        a_q     <= req_a_neg ? -bus.req_rs1 : bus.req_rs1;
        b_q     <= req_b_neg ? -bus.req_rs2 : bus.req_rs2;
        acc_q   <= '0;
        cnt_q   <= '0;
        if (special) resp_data_q <= special_data;
      end else if (state_q == MD_STATE_CALC) begin
        if (iter_done) begin
          resp_data_q <= fix_result;
        end else if (early_out) begin
          acc_q <= acc_q >> (ITER_LAST - cnt_q);
          cnt_q <= ITER_LAST;
        end else if (md_is_mul(op_q)) begin
          acc_q <= mul_next;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CNT_W'(1);
        end else begin
          acc_q <= div_next;
          a_q   <= a_q << 1;
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Outputs decode straight from the registered state.
  assign bus.req_ready  = (state_q == MD_STATE_IDLE);
  assign bus.busy       = (state_q != MD_STATE_IDLE);
  assign bus.resp_valid = (state_q == MD_STATE_DONE);
  assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq
//   Directed bench for muldiv_seq. A reference model computes RV32M results
//   with plain 64-bit arithmetic; a negedge compare process checks ready,
//   busy, resp_valid timing and resp_data every cycle. Directed tasks add
//   hand-computed literal expectations. Inputs change 1 time unit after the
//   rising edge; the compare process samples on the falling edge.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  localparam int XLEN = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_seq_if #(.XLEN(XLEN)) bus ();

  muldiv_seq #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    logic        ovf;
    longint      sa, sb, ua, ub;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0];  end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Falling edges from the accepting cycle until resp_valid is first visible.
  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    logic [31:0] mag;
    int          k;
    if (op[2] && ((b == 0) || ((op == 3'd4 || op == 3'd6) &&
                               a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    mag = (op == 3'd1 && b[31]) ? -b : b;
    k   = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) k = i + 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (!op[2] && k < 32) return k + 3;
`endif
    return 34;
  endfunction

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;

  // ---------------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic pend, exp_valid;
    exp_t e;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      pend      = (exp_q.size() > 0);
      exp_valid = 1'b0;
      if (pend) exp_valid = (cyc - exp_q[0].acc_cyc) >= exp_q[0].lat;
      check("cmp req_ready", 32'(bus.req_ready), 32'(!pend));
      check("cmp busy", 32'(bus.busy), 32'(pend));
      check("cmp resp_valid", 32'(bus.resp_valid), 32'(exp_valid));
      if (exp_valid && bus.resp_valid) check("cmp resp_data", bus.resp_data, exp_q[0].data);
      if (bus.flush) begin
        exp_q.delete();
      end else begin
        if (pend && bus.resp_valid && bus.resp_ready) void'(exp_q.pop_front());
        if (bus.req_valid && bus.req_ready) begin
          e.data    = model(bus.req_op, bus.req_rs1, bus.req_rs2);
          e.lat     = model_lat(bus.req_op, bus.req_rs1, bus.req_rs2);
          e.acc_cyc = cyc;
          exp_q.push_back(e);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus (all tasks start and end 1 unit after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic drive_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_rs1   = a;
    bus.req_rs2   = b;
  endtask

  // Waits (bounded) for resp_valid; lat counts rising edges after the accept edge.
  task automatic wait_resp(input string name, output logic ok, output int lat);
    lat = 0;
    while (!bus.resp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    ok = bus.resp_valid;
    if (!ok) check({name, " timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic ok;
    int   lat;
    drive_req(op, a, b);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_resp(name, ok, lat);
    if (ok) begin
      check(name, bus.resp_data, exp);
      if (exp_lat >= 0) check({name, " latency"}, 32'(lat), 32'(exp_lat));
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({name, " resp_data"}, bus.resp_data, 32'd0);
    check({name, " busy"}, 32'(bus.busy), 32'd0);
    check({name, " req_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic        ok;
    logic        seen_valid;
    int          lat;
    logic [31:0] ra, rb;
    logic [2:0]  rop;

    bus.req_valid  = 1'b0;
    bus.req_op     = 3'd0;
    bus.req_rs1    = '0;
    bus.req_rs2    = '0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b0;

    // Pin the model with hand-computed results.
    check("model MUL 7*-3", model(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    check("model MULHSU -1*2", model(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
    check("model DIV -7/2", model(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("model REM 100/-7", model(3'd6, 32'd100, 32'hFFFF_FFF9), 32'd2);

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("in reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("after reset");

    // Multiply group.
    do_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    do_op("MULH -1*-1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, -1);
    do_op("MULHU ff*ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, -1);
    do_op("MULHSU -1*2", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, -1);

    // Divide group.
    do_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, -1);
    do_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, -1);
    do_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, -1);
    do_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 32'd2, -1);

    // Special cases complete in the cycle right after the accepting edge.
    do_op("DIV 5/0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    do_op("REMU 5/0", 3'd7, 32'd5, 32'd0, 32'd5, 0);
    do_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    do_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

    // Mixed operands against the model.
    for (int i = 0; i < 8; i++) begin
      rop = 3'(i);
      ra  = $urandom;
      rb  = (i == 6) ? 32'hFFFF_FFF3 : $urandom;
      do_op("rand op", rop, ra, rb, model(rop, ra, rb), -1);
    end

    // Backpressure: result held, next request waits for the handshake.
    drive_req(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    drive_req(3'd5, 32'd100, 32'd7);
    wait_resp("bp MULHU", ok, lat);
    for (int i = 0; i < 10; i++) begin
      check("bp resp_data", bus.resp_data, 32'hFFFF_FFFE);
      check("bp req_ready", 32'(bus.req_ready), 32'd0);
      check("bp resp_valid", 32'(bus.resp_valid), 32'd1);
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("bp idle after handshake", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("bp next accepted", 32'(bus.busy), 32'd1);
    wait_resp("bp DIVU", ok, lat);
    if (ok) check("bp DIVU 100/7", bus.resp_data, 32'd14);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;

    // Flush mid-CALC with a competing request.
    drive_req(3'd5, 32'hFFFF_FFFF, 32'd3);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    drive_req(3'd0, 32'd3, 32'd3);
    @(posedge clk); #1;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    check("flush resp_valid", 32'(bus.resp_valid), 32'd0);
    check("flush req_ready", 32'(bus.req_ready), 32'd1);
    check("flush busy", 32'(bus.busy), 32'd0);
    check("flush keeps resp_data", bus.resp_data, 32'd14);
    seen_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen_valid = seen_valid | bus.resp_valid | bus.busy;
    end
    check("flush dropped request", 32'(seen_valid), 32'd0);
    do_op("DIVU 9/3 after flush", 3'd5, 32'd9, 32'd3, 32'd3, -1);

    // Reset pulsed mid-CALC.
    drive_req(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("post reset");
    do_op("REM 100/-7", 3'd6, 32'd100, 32'hFFFF_FFF9, 32'd2, -1);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
